// File: rtl/se_pkg.sv
// Shared types and constants for the squeeze-and-excite sequencer and datapath.
package se_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POOL  = 3'd1,
    S_FC1   = 3'd2,
    S_FC2   = 3'd3,
    S_SCALE = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } se_state_t;

  // Cycles from mac_en to a result the datapath can write back.
  localparam int unsigned MAC_LAT = 1;

  // mac_phase encoding seen by the datapath.
  localparam logic PHASE_FC1 = 1'b0;
  localparam logic PHASE_FC2 = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/se_idx_cnt.sv
// Two-level (outer/inner) index counter with enable, synchronous clear and
// wrap to zero after the final (outer, inner) pair. Next-value outputs let the
// owner register its issue strobes for the index that will be current next.
module se_idx_cnt
  import se_pkg::*;
#(
  parameter int unsigned OUTER_N = 1,
  parameter int unsigned INNER_N = 2,
  parameter int unsigned OW      = cnt_w(OUTER_N),
  parameter int unsigned IW      = cnt_w(INNER_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [OW-1:0] outer,
  output logic [IW-1:0] inner,
  output logic [OW-1:0] nxt_outer,
  output logic [IW-1:0] nxt_inner,
  output logic          inner_last,
  output logic          last,
  output logic          nxt_first
);

  // Flags on the current index and the index after this cycle's update.
  always_comb begin
    inner_last = (inner == IW'(INNER_N - 1));
    last       = inner_last && (outer == OW'(OUTER_N - 1));
    nxt_outer  = outer;
    nxt_inner  = inner;
    if (clr) begin
      nxt_outer = '0;
      nxt_inner = '0;
    end else if (en) begin
      if (inner_last) begin
        nxt_inner = '0;
        nxt_outer = last ? '0 : outer + OW'(1);
      end else begin
        nxt_inner = inner + IW'(1);
      end
    end
    nxt_first = (nxt_inner == '0);
  end

  // Index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outer <= '0;
      inner <= '0;
    end else begin
      outer <= nxt_outer;
      inner <= nxt_inner;
    end
  end

endmodule

// File: rtl/se_seq_ctrl.sv
// Squeeze-and-excite sequencer: drives the shared MAC and feature-map buffer
// through POOL, FC1, FC2 and SCALE, with a one-cycle GAP between phases.
// Optional build macro: SE_SEQ_ABORT_EN adds an 'abort' input.
module se_seq_ctrl
  import se_pkg::*;
#(
  parameter int unsigned IN_SIZE      = 16,
  parameter int unsigned SQUEEZE_SIZE = 4,
  parameter int unsigned IN_HEIGHT    = 56,
  parameter int unsigned IN_WIDTH     = 56,
  parameter int unsigned PIX_W        = $clog2(IN_HEIGHT * IN_WIDTH),
  parameter int unsigned WADDR_W      = $clog2(IN_SIZE * SQUEEZE_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               fmap_rd_en,
  output logic [PIX_W-1:0]   fmap_rd_addr,
  output logic               pool_en,
  output logic               pool_clr,
  output logic               mac_en,
  output logic               mac_clr,
  output logic               mac_phase,
  output logic [WADDR_W-1:0] w_addr,
  output logic [7:0]         src_idx,
  output logic               wb_en,
  output logic [7:0]         wb_idx,
  output logic               out_valid,
`ifdef SE_SEQ_ABORT_EN
  input  logic               out_ready,
  input  logic               abort
`else
  input  logic               out_ready
`endif
);

  localparam int unsigned HW   = IN_HEIGHT * IN_WIDTH;
  localparam int unsigned PCW  = cnt_w(HW);
  localparam int unsigned SQW  = cnt_w(SQUEEZE_SIZE);
  localparam int unsigned INW  = cnt_w(IN_SIZE);

  se_state_t state;
  se_state_t gap_next;

  logic abort_hit;
  logic cnt_clr;
  logic pix_en, fc1_en, fc2_en;

  logic [0:0]     pix_no, pix_nxt_no;
  logic [PCW-1:0] pix_ni, pix_nxt_ni;
  logic           pix_ilast, pix_last, pix_nfirst;

  logic [SQW-1:0] fc1_no, fc1_nxt_no;
  logic [INW-1:0] fc1_ni, fc1_nxt_ni;
  logic           fc1_ilast, fc1_last, fc1_nfirst;

  logic [INW-1:0] fc2_no, fc2_nxt_no;
  logic [SQW-1:0] fc2_ni, fc2_nxt_ni;
  logic           fc2_ilast, fc2_last, fc2_nfirst;

  logic [PIX_W-1:0]   pix_addr_n;
  logic [WADDR_W-1:0] fc1_waddr_n, fc2_waddr_n;
  logic [7:0]         fc1_src_n, fc2_src_n, fc1_wb_n, fc2_wb_n;

  logic cnt_unused;
  assign cnt_unused = ^{pix_no, pix_ni, pix_nxt_no, pix_ilast, fc1_ni, fc2_ni};

`ifdef SE_SEQ_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif
  assign cnt_clr = abort_hit;

  // Counter advance: one step per issued pixel / product, SCALE only on handshake.
  always_comb begin
    pix_en = (state == S_POOL) || ((state == S_SCALE) && out_valid && out_ready);
    fc1_en = (state == S_FC1);
    fc2_en = (state == S_FC2);
  end

  se_idx_cnt #(.OUTER_N(1), .INNER_N(HW)) u_pix (
    .clk(clk), .rst(rst), .en(pix_en), .clr(cnt_clr),
    .outer(pix_no), .inner(pix_ni), .nxt_outer(pix_nxt_no), .nxt_inner(pix_nxt_ni),
    .inner_last(pix_ilast), .last(pix_last), .nxt_first(pix_nfirst)
  );

  se_idx_cnt #(.OUTER_N(SQUEEZE_SIZE), .INNER_N(IN_SIZE)) u_fc1 (
    .clk(clk), .rst(rst), .en(fc1_en), .clr(cnt_clr),
    .outer(fc1_no), .inner(fc1_ni), .nxt_outer(fc1_nxt_no), .nxt_inner(fc1_nxt_ni),
    .inner_last(fc1_ilast), .last(fc1_last), .nxt_first(fc1_nfirst)
  );

  se_idx_cnt #(.OUTER_N(IN_SIZE), .INNER_N(SQUEEZE_SIZE)) u_fc2 (
    .clk(clk), .rst(rst), .en(fc2_en), .clr(cnt_clr),
    .outer(fc2_no), .inner(fc2_ni), .nxt_outer(fc2_nxt_no), .nxt_inner(fc2_nxt_ni),
    .inner_last(fc2_ilast), .last(fc2_last), .nxt_first(fc2_nfirst)
  );

  // Issue values for the index that becomes current after this edge.
  always_comb begin
    pix_addr_n  = PIX_W'(pix_nxt_ni);
    fc1_waddr_n = WADDR_W'(32'(fc1_nxt_no) * IN_SIZE + 32'(fc1_nxt_ni));
    fc2_waddr_n = WADDR_W'(32'(fc2_nxt_no) * SQUEEZE_SIZE + 32'(fc2_nxt_ni));
    fc1_src_n   = 8'(fc1_nxt_ni);
    fc2_src_n   = 8'(fc2_nxt_ni);
    fc1_wb_n    = 8'(fc1_no);
    fc2_wb_n    = 8'(fc2_no);
  end

  // Phase sequencing with registered strobes. Outputs are loaded from the
  // counters' next values so each strobe lines up with the index it names;
  // writeback trails the last product of a dot product by MAC_LAT (=1) cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      gap_next     <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      fmap_rd_en   <= 1'b0;
      fmap_rd_addr <= '0;
      pool_en      <= 1'b0;
      pool_clr     <= 1'b0;
      mac_en       <= 1'b0;
      mac_clr      <= 1'b0;
      mac_phase    <= PHASE_FC1;
      w_addr       <= '0;
      src_idx      <= '0;
      wb_en        <= 1'b0;
      wb_idx       <= '0;
      out_valid    <= 1'b0;
    end else begin
      done         <= 1'b0;
      fmap_rd_en   <= 1'b0;
      fmap_rd_addr <= '0;
      pool_en      <= 1'b0;
      pool_clr     <= 1'b0;
      mac_en       <= 1'b0;
      mac_clr      <= 1'b0;
      mac_phase    <= PHASE_FC1;
      w_addr       <= '0;
      src_idx      <= '0;
      wb_en        <= 1'b0;
      wb_idx       <= '0;
      out_valid    <= 1'b0;
      if (abort_hit) begin
        state    <= S_IDLE;
        gap_next <= S_IDLE;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state        <= S_POOL;
              busy         <= 1'b1;
              fmap_rd_en   <= 1'b1;
              pool_en      <= 1'b1;
              pool_clr     <= pix_nfirst;
              fmap_rd_addr <= pix_addr_n;
            end
          end
          S_POOL: begin
            if (pix_last) begin
              state    <= S_GAP;
              gap_next <= S_FC1;
            end else begin
              fmap_rd_en   <= 1'b1;
              pool_en      <= 1'b1;
              pool_clr     <= pix_nfirst;
              fmap_rd_addr <= pix_addr_n;
            end
          end
          S_FC1: begin
            if (fc1_ilast) begin
              wb_en  <= 1'b1;
              wb_idx <= fc1_wb_n;
            end
            if (fc1_last) begin
              state    <= S_GAP;
              gap_next <= S_FC2;
            end else begin
              mac_en  <= 1'b1;
              mac_clr <= fc1_nfirst;
              w_addr  <= fc1_waddr_n;
              src_idx <= fc1_src_n;
            end
          end
          S_FC2: begin
            mac_phase <= PHASE_FC2;
            if (fc2_ilast) begin
              wb_en  <= 1'b1;
              wb_idx <= fc2_wb_n;
            end
            if (fc2_last) begin
              state    <= S_GAP;
              gap_next <= S_SCALE;
            end else begin
              mac_en  <= 1'b1;
              mac_clr <= fc2_nfirst;
              w_addr  <= fc2_waddr_n;
              src_idx <= fc2_src_n;
            end
          end
          S_GAP: begin
            state    <= gap_next;
            gap_next <= S_IDLE;
            case (gap_next)
              S_FC1: begin
                mac_en  <= 1'b1;
                mac_clr <= fc1_nfirst;
                w_addr  <= fc1_waddr_n;
                src_idx <= fc1_src_n;
              end
              S_FC2: begin
                mac_en    <= 1'b1;
                mac_clr   <= fc2_nfirst;
                mac_phase <= PHASE_FC2;
                w_addr    <= fc2_waddr_n;
                src_idx   <= fc2_src_n;
              end
              S_SCALE: begin
                fmap_rd_en   <= 1'b1;
                out_valid    <= 1'b1;
                fmap_rd_addr <= pix_addr_n;
              end
              default: begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
          S_SCALE: begin
            if (out_valid && out_ready && pix_last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              fmap_rd_en   <= 1'b1;
              out_valid    <= 1'b1;
              fmap_rd_addr <= pix_addr_n;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_se_seq_ctrl.sv
// Scoreboard bench for se_seq_ctrl at IN_SIZE=4, SQUEEZE_SIZE=2, 2x2 map.
// When a start is accepted the whole per-cycle output sequence of the pass is
// pushed; each mid-cycle sample pops one entry, or expects idle zeros.
module tb_se_seq_ctrl;

  localparam int IN  = 4;
  localparam int SQ  = 2;
  localparam int HH  = 2;
  localparam int WW  = 2;
  localparam int HW  = HH * WW;
  localparam int PIX_W   = 2;
  localparam int WADDR_W = 3;
  localparam int LAST_CYC = 280;

  typedef logic [31:0] vec_t;

  logic clk = 1'b0;
  logic rst, start, out_ready, abort;
  logic busy, done, fmap_rd_en, pool_en, pool_clr, mac_en, mac_clr, mac_phase;
  logic wb_en, out_valid;
  logic [PIX_W-1:0]   fmap_rd_addr;
  logic [WADDR_W-1:0] w_addr;
  logic [7:0]         src_idx, wb_idx;

  int n_checks = 0;
  int n_errors = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  se_seq_ctrl #(
    .IN_SIZE(IN), .SQUEEZE_SIZE(SQ), .IN_HEIGHT(HH), .IN_WIDTH(WW),
    .PIX_W(PIX_W), .WADDR_W(WADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fmap_rd_en(fmap_rd_en), .fmap_rd_addr(fmap_rd_addr),
    .pool_en(pool_en), .pool_clr(pool_clr),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_phase(mac_phase),
    .w_addr(w_addr), .src_idx(src_idx), .wb_en(wb_en), .wb_idx(wb_idx),
    .out_valid(out_valid),
`ifdef SE_SEQ_ABORT_EN
    .out_ready(out_ready),
    .abort(abort)
`else
    .out_ready(out_ready)
`endif
  );

  task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input bit bz, input bit dn, input bit rd, input int addr,
                              input bit pe, input bit pc, input bit me, input bit mc,
                              input bit ph, input int wa, input int src, input bit we,
                              input int wi, input bit ov);
    return {1'b0, bz, dn, rd, PIX_W'(addr), pe, pc, me, mc, ph, WADDR_W'(wa),
            8'(src), we, 8'(wi), ov};
  endfunction

  function automatic vec_t dut_vec();
    return {1'b0, busy, done, fmap_rd_en, fmap_rd_addr, pool_en, pool_clr, mac_en,
            mac_clr, mac_phase, w_addr, src_idx, wb_en, wb_idx, out_valid};
  endfunction

  function automatic bit start_at(input int n);
    return (n == 0) || (n == 40) || (n == 50) || (n == 68) ||
           (n >= 80 && n <= 114) || (n == 150) || (n == 156) || (n == 170) ||
           (n == 210) || (n == 240);
  endfunction

  function automatic bit ready_at(input int n);
    return !(n == 65 || n == 66);
  endfunction

  function automatic bit abort_at(input int n);
`ifdef SE_SEQ_ABORT_EN
    return (n == 227) || (n == 240);
`else
    return (n < 0);
`endif
  endfunction

  // Expected outputs for cycles n0+1 .. done+1 of a pass whose start is sampled at edge n0.
  task automatic gen_pass(input int n0);
    int c;
    int p;
    bit pend;
    int pidx;
    c = n0 + 1;
    for (int i = 0; i < HW; i++) begin
      q.push_back(mk(1, 0, 1, i, 1, i == 0, 0, 0, 0, 0, 0, 0, 0, 0));
      c++;
    end
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    c++;
    pend = 0;
    pidx = 0;
    for (int j = 0; j < SQ; j++) begin
      for (int i = 0; i < IN; i++) begin
        q.push_back(mk(1, 0, 0, 0, 0, 0, 1, i == 0, 0, j * IN + i, i, pend, pend ? pidx : 0, 0));
        pend = (i == IN - 1);
        pidx = j;
        c++;
      end
    end
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pend, pend ? pidx : 0, 0));
    c++;
    pend = 0;
    for (int k = 0; k < IN; k++) begin
      for (int j = 0; j < SQ; j++) begin
        q.push_back(mk(1, 0, 0, 0, 0, 0, 1, j == 0, 1, k * SQ + j, j, pend, pend ? pidx : 0, 0));
        pend = (j == SQ - 1);
        pidx = k;
        c++;
      end
    end
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, pend, pend ? pidx : 0, 0));
    c++;
    p = 0;
    while (p < HW) begin
      q.push_back(mk(1, 0, 1, p, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      if (ready_at(c)) p++;
      c++;
    end
    q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset", dut_vec(), '0);
    rst = 1'b0;

    for (int n = 0; n <= LAST_CYC; n++) begin
      @(negedge clk);
      if (q.size() > 0) check_eq($sformatf("cyc%0d", n), dut_vec(), q.pop_front());
      else              check_eq($sformatf("idle%0d", n), dut_vec(), '0);

      start     = start_at(n);
      out_ready = ready_at(n);
      abort     = abort_at(n);

      if (n == 163) rst = 1'b0;
      if (n == 162) begin
        rst = 1'b1;
        q.delete();
      end else if (abort && q.size() > 0) begin
        q.delete();
      end else if (!rst && q.size() == 0 && start && !abort) begin
        gen_pass(n);
      end
    end

    check_eq("drain", vec_t'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
